uart_ctrl_regs: RTL and testbench
=================================

# uart_ctrl_regs

Parametrised, bus-addressed control/status front end for the UART core; successor to the fixed-pin UART interface unit. Sits between the system register bus and the TX/RX datapaths and FIFOs: it holds configuration and baud registers, sequences enable/disable through a state machine with TX drain, keeps sticky error flags with write-1-to-clear, and raises a maskable interrupt.

## Interface
- `BUS_W`, 16: bus data width, 16 or 32; bits above 15 read 0 and ignore writes.
- `FIFO_AW`, 4: FIFO address width; level inputs are `FIFO_AW+1` bits.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `bus_sel` in 1: access strobe, one access per cycle.
- `bus_wr` in 1: 1 = write, 0 = read.
- `bus_addr` in 3: register index.
- `bus_wdata` in BUS_W: write data.
- `bus_rdata` out BUS_W: registered read data.
- `bus_rvalid` out 1: one-cycle pulse with `bus_rdata`.
- `tx_push` out 1, `tx_data` out 8: TX FIFO write.
- `rx_pop` out 1: RX FIFO read.
- `rx_data` in 8: RX FIFO head.
- `tx_full`, `tx_empty`, `tx_busy`, `tx_lvl_irq` in 1 each: TX status.
- `rx_full`, `rx_empty`, `rx_fe`, `rx_pe`, `rx_be`, `rx_oe`, `rx_lvl_irq` in 1 each: RX status; error inputs are single-cycle pulses.
- `tx_count`, `rx_count` in FIFO_AW+1: FIFO fill levels.
- `cfg_bits` out 4: data bits, 5..8.
- `cfg_stop2`, `cfg_par_en`, `cfg_par_even`, `cfg_tx_en`, `cfg_rx_en` out 1 each: frame and enable settings.
- `tx_lvl_sel`, `rx_lvl_sel` out 3: FIFO interrupt level selects.
- `baud_div` out 16: baud divisor.
- `baudgen_en` out 1: baud generator enable.
- `irq` out 1: interrupt.

## Operation
- Register map:
  - 0 CONFIG rw: [0] rx_en, [1] tx_en, [2] par_en, [3] par_even, [4] stop2, [6:5] width code (00=5 … 11=8), [9:7] tx lvl, [12:10] rx lvl, [15] enable. Reset value 0x0060.
  - 1 BAUD rw: reset value 0.
  - 2 STATUS: [0] running, [1] fe, [2] pe, [3] be, [4] oe, [5] tx_busy, [6] rx_empty, [7] tx_full, [8] rx_full, [9] tx_empty, [10] tx_lvl_irq, [11] rx_lvl_irq, [12] tx_ovf, [13] rx_unf, [15:14] state. Bits 1–4 and 12–13 are sticky and W1C; the remaining bits are live.
  - 3 DATA: a write pushes to TX; a read pops from RX.
  - 4 INT_EN rw: mask over STATUS[13:1].
  - 5 reserved.
  - 6 LEVEL ro: {rx_count, tx_count} packed from bit 0, truncated to BUS_W.
  - 7 reads 0.
- FSM states and transitions:
  - DISABLE(00) → INIT when CONFIG.enable = 1.
  - INIT(01) lasts exactly one cycle: copies CONFIG into the shadow `cfg_*` outputs and the baud register into `baud_div`, then moves to RUNNING.
  - RUNNING(10) → DRAIN when enable = 0.
  - DRAIN(11) → DISABLE when `tx_empty & ~tx_busy`. Returns to RUNNING if enable goes back to 1. Pushes are refused while in DRAIN.
- Shadow outputs change only in INIT. CONFIG/BAUD writes made while RUNNING take effect on the next enable cycle.
- `baudgen_en` is 1 in RUNNING and DRAIN, 0 otherwise.
- DATA write:
  - RUNNING, tx_en = 1, not full: `tx_push` = 1 in the same cycle, `tx_data` = wdata[7:0].
  - Full: write dropped, tx_ovf set.
  - Any other state, or tx_en = 0: write ignored, no flag.
- DATA read:
  - RUNNING, rx_en = 1, not empty: `rx_pop` = 1 in the same cycle; `rx_data` is captured into `bus_rdata`.
  - Empty: rdata = 0, rx_unf set.
- Sticky flags: set by their event pulse, cleared by writing 1. If a set and a W1C happen in the same cycle, the set wins.
- `irq` = |(STATUS[13:1] & INT_EN[13:1]), registered.

## Timing
- Writes take effect at the clock edge where `bus_sel & bus_wr` is seen.
- Reads: `bus_rdata` and `bus_rvalid` appear one cycle after the request. `bus_rvalid` = 0 otherwise, and `bus_rdata` holds its last value.
- `tx_push` and `rx_pop` are combinational from the bus strobe, at most one per cycle.
- Enable to `baudgen_en`: enable is written at edge N, INIT is entered at N+1, RUNNING and `baudgen_en` = 1 at N+2.
- `irq` rises one cycle after the flag sets.
- Reset, including mid-operation: all registers return to reset values. State = DISABLE. Shadow values are 8 bits, no parity, 1 stop, tx/rx disabled. `baud_div` = 0. All outputs = 0 except `cfg_bits` = 8.

## Configuration
- `UART_CTRL_IRQ_EN` defined: INT_EN register, sticky-flag masking and `irq` are built in.
- `UART_CTRL_IRQ_EN` undefined: INT_EN reads 0 and ignores writes, `irq` is tied to 0, and no mask logic is built. Sticky flags and W1C still operate.

## Structure
- Package `uart_pkg`:
  - register address constants
  - FSM state encoding (DISABLE/INIT/RUNNING/DRAIN)
  - STATUS and CONFIG bit-index constants
  - CONFIG reset value
  - width-code-to-bits function
- One sub-module, `uart_sticky_flags`: per-bit set/W1C register with set-wins priority.

## Test plan
- Write CONFIG = 0x8063, BAUD = 0x0145 → `baudgen_en` = 1 two cycles later; `cfg_bits` = 8, `cfg_rx_en` = `cfg_tx_en` = 1, `baud_div` = 0x0145.
- While RUNNING, write DATA = 0x1A5 → `tx_push` pulse with `tx_data` = 0xA5. With `tx_full` = 1 → no push, STATUS[12] = 1, `irq` = 1 if INT_EN[12] = 1.
- Read DATA with `rx_data` = 0x3C, not empty → `rx_pop` pulse, next cycle `bus_rdata` = 0x003C with `bus_rvalid`. When empty → rdata 0, STATUS[13] set.
- `rx_fe` pulse in the same cycle as a W1C of bit 1 → STATUS[1] stays 1. A second W1C clears it and `irq` drops.
- Clear enable while `tx_busy` = 1 → state = DRAIN, `baudgen_en` = 1. `tx_busy` drops with `tx_empty` = 1 → DISABLE, `baudgen_en` = 0.
- Assert reset while RUNNING → all outputs return to reset values immediately; STATUS read returns 0x0000 plus live input bits.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART control/status front end: register
// addresses, FSM state encoding, CONFIG/STATUS bit positions, CONFIG reset
// value and the data-width decode helper.
// No ports (package).
package uart_pkg;

    localparam logic [2:0] ADDR_CONFIG = 3'd0;
    localparam logic [2:0] ADDR_BAUD   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_DATA   = 3'd3;
    localparam logic [2:0] ADDR_INT_EN = 3'd4;
    localparam logic [2:0] ADDR_LEVEL  = 3'd6;

    typedef enum logic [1:0] {
        ST_DISABLE = 2'b00,
        ST_INIT    = 2'b01,
        ST_RUNNING = 2'b10,
        ST_DRAIN   = 2'b11
    } uart_state_e;

    localparam int CFG_RX_EN    = 0;
    localparam int CFG_TX_EN    = 1;
    localparam int CFG_PAR_EN   = 2;
    localparam int CFG_PAR_EVEN = 3;
    localparam int CFG_STOP2    = 4;
    localparam int CFG_WIDTH_LO = 5;
    localparam int CFG_TXLVL_LO = 7;
    localparam int CFG_RXLVL_LO = 10;
    localparam int CFG_ENABLE   = 15;

    // Bits 13 and 14 of CONFIG have no function and are not stored.
    localparam logic [15:0] CONFIG_RST  = 16'h0060;
    localparam logic [15:0] CONFIG_MASK = 16'h9FFF;

    localparam int STS_RUNNING  = 0;
    localparam int STS_FE       = 1;
    localparam int STS_PE       = 2;
    localparam int STS_BE       = 3;
    localparam int STS_OE       = 4;
    localparam int STS_TX_BUSY  = 5;
    localparam int STS_RX_EMPTY = 6;
    localparam int STS_TX_FULL  = 7;
    localparam int STS_RX_FULL  = 8;
    localparam int STS_TX_EMPTY = 9;
    localparam int STS_TX_LVL   = 10;
    localparam int STS_RX_LVL   = 11;
    localparam int STS_TX_OVF   = 12;
    localparam int STS_RX_UNF   = 13;
    localparam int STS_STATE_LO = 14;

    localparam int N_STICKY = 6;

    // Width code 00..11 maps to 5..8 data bits.
    function automatic logic [3:0] width_to_bits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_sticky_flags.sv
// uart_sticky_flags
// Bank of sticky event flags. Each bit sets on its event pulse and clears on a
// write-1-to-clear; when both happen in the same cycle the set wins.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   set [N-1:0]     event pulses
//   clr [N-1:0]     W1C strobes (already qualified by the register write)
//   flags [N-1:0]   current flag state
module uart_sticky_flags #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] set,
    input  logic [N-1:0] clr,
    output logic [N-1:0] flags
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
        end else begin
            flags <= (flags & ~clr) | set;
        end
    end

endmodule

// File: rtl/uart_ctrl_regs.sv
// uart_ctrl_regs
// Bus-addressed control/status front end for the UART core. Holds CONFIG and
// BAUD, sequences enable/disable with a TX drain phase, copies configuration
// into shadow outputs only when entering operation, keeps sticky error flags
// with W1C, and raises a maskable registered interrupt.
// Optional feature macro: UART_CTRL_IRQ_EN (INT_EN register, masking and irq).
// Without it INT_EN reads 0 and irq is tied low.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   bus_sel/wr/addr/wdata            register access strobe and write data
//   bus_rdata, bus_rvalid            registered read data, one-cycle valid
//   tx_push, tx_data                 TX FIFO write
//   rx_pop, rx_data                  RX FIFO read and head data
//   tx_*/rx_* status, counts         live FIFO/datapath status, error pulses
//   cfg_*, tx/rx_lvl_sel, baud_div   shadow configuration
//   baudgen_en                       baud generator enable
//   irq                              interrupt
//
// FSM states:
//   state   | meaning
//   DISABLE | idle, shadow config held, baud generator off
//   INIT    | one cycle, shadow config loaded from CONFIG/BAUD
//   RUNNING | normal operation, DATA accesses reach the FIFOs
//   DRAIN   | disable requested, waiting for TX to go idle
module uart_ctrl_regs
    import uart_pkg::*;
#(
    parameter int BUS_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bus_sel,
    input  logic               bus_wr,
    input  logic [2:0]         bus_addr,
    input  logic [BUS_W-1:0]   bus_wdata,
    output logic [BUS_W-1:0]   bus_rdata,
    output logic               bus_rvalid,
    output logic               tx_push,
    output logic [7:0]         tx_data,
    output logic               rx_pop,
    input  logic [7:0]         rx_data,
    input  logic               tx_full,
    input  logic               tx_empty,
    input  logic               tx_busy,
    input  logic               tx_lvl_irq,
    input  logic               rx_full,
    input  logic               rx_empty,
    input  logic               rx_fe,
    input  logic               rx_pe,
    input  logic               rx_be,
    input  logic               rx_oe,
    input  logic               rx_lvl_irq,
    input  logic [FIFO_AW:0]   tx_count,
    input  logic [FIFO_AW:0]   rx_count,
    output logic [3:0]         cfg_bits,
    output logic               cfg_stop2,
    output logic               cfg_par_en,
    output logic               cfg_par_even,
    output logic               cfg_tx_en,
    output logic               cfg_rx_en,
    output logic [2:0]         tx_lvl_sel,
    output logic [2:0]         rx_lvl_sel,
    output logic [15:0]        baud_div,
    output logic               baudgen_en,
    output logic               irq
);

    uart_state_e state_q, state_d;

    logic [15:0]          config_reg;
    logic [15:0]          baud_reg;
    logic [15:0]          status_word;
    logic [15:0]          int_en_word;
    logic [BUS_W-1:0]     rd_word;
    logic [N_STICKY-1:0]  sticky_set, sticky_clr, sticky;
    logic                 running, load_shadow;
    logic                 wr_strobe, rd_strobe, data_wr, data_rd, tx_ok, rx_ok;
    logic                 tx_ovf_set, rx_unf_set;

    assign wr_strobe = bus_sel & bus_wr;
    assign rd_strobe = bus_sel & ~bus_wr;
    assign data_wr   = wr_strobe && (bus_addr == ADDR_DATA);
    assign data_rd   = rd_strobe && (bus_addr == ADDR_DATA);

    // DATA accesses only reach the FIFOs in RUNNING with the shadow enable set.
    assign tx_ok      = running & cfg_tx_en;
    assign rx_ok      = running & cfg_rx_en;
    assign tx_push    = data_wr & tx_ok & ~tx_full;
    assign tx_ovf_set = data_wr & tx_ok & tx_full;
    assign tx_data    = tx_push ? bus_wdata[7:0] : 8'h00;
    assign rx_pop     = data_rd & rx_ok & ~rx_empty;
    assign rx_unf_set = data_rd & rx_ok & rx_empty;

    // CONFIG and BAUD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            config_reg <= CONFIG_RST;
            baud_reg   <= 16'h0000;
        end else if (wr_strobe) begin
            if (bus_addr == ADDR_CONFIG) config_reg <= bus_wdata[15:0] & CONFIG_MASK;
            if (bus_addr == ADDR_BAUD)   baud_reg   <= bus_wdata[15:0];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_DISABLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISABLE: if (config_reg[CFG_ENABLE]) state_d = ST_INIT;
            ST_INIT:    state_d = ST_RUNNING;
            ST_RUNNING: if (!config_reg[CFG_ENABLE]) state_d = ST_DRAIN;
            ST_DRAIN: begin
                // Re-enable during drain resumes without a fresh INIT.
                if (config_reg[CFG_ENABLE])      state_d = ST_RUNNING;
                else if (tx_empty && !tx_busy)   state_d = ST_DISABLE;
            end
            default:    state_d = ST_DISABLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        baudgen_en  = 1'b0;
        running     = 1'b0;
        load_shadow = 1'b0;
        case (state_q)
            ST_INIT:    load_shadow = 1'b1;
            ST_RUNNING: begin
                baudgen_en = 1'b1;
                running    = 1'b1;
            end
            ST_DRAIN:   baudgen_en = 1'b1;
            default:    ;
        endcase
    end

    // Shadow configuration, loaded only during INIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_bits     <= 4'd8;
            cfg_stop2    <= 1'b0;
            cfg_par_en   <= 1'b0;
            cfg_par_even <= 1'b0;
            cfg_tx_en    <= 1'b0;
            cfg_rx_en    <= 1'b0;
            tx_lvl_sel   <= 3'd0;
            rx_lvl_sel   <= 3'd0;
            baud_div     <= 16'h0000;
        end else if (load_shadow) begin
            cfg_bits     <= width_to_bits(config_reg[CFG_WIDTH_LO +: 2]);
            cfg_stop2    <= config_reg[CFG_STOP2];
            cfg_par_en   <= config_reg[CFG_PAR_EN];
            cfg_par_even <= config_reg[CFG_PAR_EVEN];
            cfg_tx_en    <= config_reg[CFG_TX_EN];
            cfg_rx_en    <= config_reg[CFG_RX_EN];
            tx_lvl_sel   <= config_reg[CFG_TXLVL_LO +: 3];
            rx_lvl_sel   <= config_reg[CFG_RXLVL_LO +: 3];
            baud_div     <= baud_reg;
        end
    end

    // Sticky flag order: fe, pe, be, oe, tx_ovf, rx_unf
    assign sticky_set = {rx_unf_set, tx_ovf_set, rx_oe, rx_be, rx_pe, rx_fe};
    assign sticky_clr = (wr_strobe && (bus_addr == ADDR_STATUS))
                      ? {bus_wdata[STS_RX_UNF], bus_wdata[STS_TX_OVF], bus_wdata[STS_OE:STS_FE]}
                      : '0;

    uart_sticky_flags #(.N(N_STICKY)) u_sticky (
        .clk   (clk),
        .reset (reset),
        .set   (sticky_set),
        .clr   (sticky_clr),
        .flags (sticky)
    );

    always_comb begin
        status_word                   = '0;
        status_word[STS_RUNNING]      = running;
        status_word[STS_OE:STS_FE]    = sticky[3:0];
        status_word[STS_TX_BUSY]      = tx_busy;
        status_word[STS_RX_EMPTY]     = rx_empty;
        status_word[STS_TX_FULL]      = tx_full;
        status_word[STS_RX_FULL]      = rx_full;
        status_word[STS_TX_EMPTY]     = tx_empty;
        status_word[STS_TX_LVL]       = tx_lvl_irq;
        status_word[STS_RX_LVL]       = rx_lvl_irq;
        status_word[STS_TX_OVF]       = sticky[4];
        status_word[STS_RX_UNF]       = sticky[5];
        status_word[STS_STATE_LO +: 2] = state_q;
    end

`ifdef UART_CTRL_IRQ_EN
    logic [13:1] int_en;
    logic        irq_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_en <= '0;
        end else if (wr_strobe && (bus_addr == ADDR_INT_EN)) begin
            int_en <= bus_wdata[13:1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(status_word[13:1] & int_en);
        end
    end

    assign int_en_word = {2'b00, int_en, 1'b0};
    assign irq         = irq_q;
`else
    assign int_en_word = 16'h0000;
    assign irq         = 1'b0;
`endif

    always_comb begin
        rd_word = '0;
        case (bus_addr)
            ADDR_CONFIG: rd_word = BUS_W'(config_reg);
            ADDR_BAUD:   rd_word = BUS_W'(baud_reg);
            ADDR_STATUS: rd_word = BUS_W'(status_word);
            ADDR_DATA:   rd_word = BUS_W'(rx_pop ? rx_data : 8'h00);
            ADDR_INT_EN: rd_word = BUS_W'(int_en_word);
            ADDR_LEVEL:  rd_word = BUS_W'({rx_count, tx_count});
            default:     rd_word = '0;
        endcase
    end

    // Read data holds its last value between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_rdata  <= '0;
            bus_rvalid <= 1'b0;
        end else begin
            bus_rvalid <= rd_strobe;
            if (rd_strobe) bus_rdata <= rd_word;
        end
    end

endmodule

// File: tb/tb_uart_ctrl_regs.sv
// tb_uart_ctrl_regs
// Self-checking bench for uart_ctrl_regs: register-map vector table, directed
// sequences for enable/drain/W1C/reset corners, and a randomized phase checked
// against a behavioural model of STATUS, the sticky flags and irq.
module tb_uart_ctrl_regs;

    localparam int BUS_W   = 16;
    localparam int FIFO_AW = 4;

`ifdef UART_CTRL_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    localparam logic [2:0] A_CONFIG = 3'd0, A_BAUD = 3'd1, A_STATUS = 3'd2,
                           A_DATA = 3'd3, A_INT_EN = 3'd4, A_RSVD = 3'd5,
                           A_LEVEL = 3'd6, A_ZERO = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bus_sel = 1'b0, bus_wr = 1'b0;
    logic [2:0] bus_addr = '0;
    logic [BUS_W-1:0] bus_wdata = '0;
    logic [BUS_W-1:0] bus_rdata;
    logic bus_rvalid, tx_push, rx_pop;
    logic [7:0] tx_data;
    logic [7:0] rx_data = '0;
    logic tx_full = 0, tx_empty = 1, tx_busy = 0, tx_lvl_irq = 0;
    logic rx_full = 0, rx_empty = 1, rx_fe = 0, rx_pe = 0, rx_be = 0, rx_oe = 0, rx_lvl_irq = 0;
    logic [FIFO_AW:0] tx_count = '0, rx_count = '0;
    logic [3:0] cfg_bits;
    logic cfg_stop2, cfg_par_en, cfg_par_even, cfg_tx_en, cfg_rx_en;
    logic [2:0] tx_lvl_sel, rx_lvl_sel;
    logic [15:0] baud_div;
    logic baudgen_en, irq;

    int n_tests = 0;
    int n_fail = 0;

    logic s_push, s_pop, s_rv;
    logic [7:0] s_txd;
    logic [15:0] s_rd;

    always #5 clk = ~clk;

    uart_ctrl_regs #(.BUS_W(BUS_W), .FIFO_AW(FIFO_AW)) dut (
        .clk(clk), .reset(reset),
        .bus_sel(bus_sel), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .tx_push(tx_push), .tx_data(tx_data), .rx_pop(rx_pop), .rx_data(rx_data),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy), .tx_lvl_irq(tx_lvl_irq),
        .rx_full(rx_full), .rx_empty(rx_empty), .rx_fe(rx_fe), .rx_pe(rx_pe),
        .rx_be(rx_be), .rx_oe(rx_oe), .rx_lvl_irq(rx_lvl_irq),
        .tx_count(tx_count), .rx_count(rx_count),
        .cfg_bits(cfg_bits), .cfg_stop2(cfg_stop2), .cfg_par_en(cfg_par_en),
        .cfg_par_even(cfg_par_even), .cfg_tx_en(cfg_tx_en), .cfg_rx_en(cfg_rx_en),
        .tx_lvl_sel(tx_lvl_sel), .rx_lvl_sel(rx_lvl_sel), .baud_div(baud_div),
        .baudgen_en(baudgen_en), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus cycle; comb outputs sampled during it, registered ones after the edge.
    task automatic access(input logic wr, input logic [2:0] addr, input logic [15:0] wd,
                          input logic [3:0] err);
        @(negedge clk);
        bus_sel = 1'b1; bus_wr = wr; bus_addr = addr; bus_wdata = wd;
        {rx_oe, rx_be, rx_pe, rx_fe} = err;
        #1;
        s_push = tx_push; s_pop = rx_pop; s_txd = tx_data;
        @(posedge clk); #1;
        bus_sel = 1'b0; bus_wr = 1'b0;
        {rx_oe, rx_be, rx_pe, rx_fe} = 4'b0000;
        s_rd = bus_rdata; s_rv = bus_rvalid;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // STATUS as the register map defines it, from the state code and sticky bits.
    function automatic logic [15:0] exp_status(input logic [1:0] st, input logic [15:0] sticky);
        logic [15:0] v;
        v = sticky & 16'h301E;
        v[0]  = (st == 2'b10);
        v[5]  = tx_busy;
        v[6]  = rx_empty;
        v[7]  = tx_full;
        v[8]  = rx_full;
        v[9]  = tx_empty;
        v[10] = tx_lvl_irq;
        v[11] = rx_lvl_irq;
        v[15:14] = st;
        return v;
    endfunction

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] wd;
        logic [15:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] m_sticky, m_set, m_clr, b, wd, cfg_seen;
        logic [3:0] err;
        int op;
        bit done;

        do_reset();

        // ---- reset values ----
        check("rst_rdata", bus_rdata, 0);
        check("rst_rvalid", bus_rvalid, 0);
        check("rst_cfg_bits", cfg_bits, 8);
        check("rst_cfg_misc", {cfg_stop2, cfg_par_en, cfg_par_even, cfg_tx_en, cfg_rx_en}, 0);
        check("rst_baud_div", baud_div, 0);
        check("rst_baudgen", baudgen_en, 0);
        check("rst_irq", irq, 0);
        access(1'b0, A_CONFIG, 16'h0, 4'h0);
        check("rst_config", s_rd, 16'h0060);
        check("rst_rvalid_pulse", s_rv, 1);
        @(posedge clk); #1;
        check("rvalid_drops", bus_rvalid, 0);
        check("rdata_holds", bus_rdata, 16'h0060);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("rst_status", s_rd, exp_status(2'b00, 16'h0));

        // ---- register map table ----
        tx_count = 5'h05; rx_count = 5'h13;
        vecs[0] = '{A_CONFIG, 16'h1A5C, 16'h1A5C};
        vecs[1] = '{A_BAUD,   16'hBEEF, 16'hBEEF};
        vecs[2] = '{A_INT_EN, 16'hFFFF, IRQ_BUILD ? 16'h3FFE : 16'h0000};
        vecs[3] = '{A_RSVD,   16'hFFFF, 16'h0000};
        vecs[4] = '{A_LEVEL,  16'hFFFF, 16'h0265};
        vecs[5] = '{A_ZERO,   16'h1234, 16'h0000};
        for (int i = 0; i < 6; i++) begin
            access(1'b1, vecs[i].addr, vecs[i].wd, 4'h0);
            access(1'b0, vecs[i].addr, 16'h0, 4'h0);
            check($sformatf("regmap_%0d", i), s_rd, vecs[i].exp);
        end
        check("shadow_static_bits", cfg_bits, 8);
        check("shadow_static_baud", baud_div, 0);
        check("disabled_baudgen", baudgen_en, 0);

        // ---- enable sequence ----
        do_reset();
        access(1'b1, A_BAUD, 16'h0145, 4'h0);
        access(1'b1, A_INT_EN, 16'h1000, 4'h0);
        access(1'b1, A_CONFIG, 16'h8063, 4'h0);
        check("en_edge_n", baudgen_en, 0);
        @(posedge clk); #1;
        check("en_edge_n1", baudgen_en, 0);
        @(posedge clk); #1;
        check("en_edge_n2", baudgen_en, 1);
        check("en_cfg_bits", cfg_bits, 8);
        check("en_rx_tx_en", {cfg_rx_en, cfg_tx_en}, 2'b11);
        check("en_baud_div", baud_div, 16'h0145);

        // ---- TX push / overflow ----
        access(1'b1, A_DATA, 16'h01A5, 4'h0);
        check("push_pulse", s_push, 1);
        check("push_data", s_txd, 8'hA5);
        tx_full = 1'b1;
        access(1'b1, A_DATA, 16'h0077, 4'h0);
        check("full_no_push", s_push, 0);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("ovf_status", s_rd, exp_status(2'b10, 16'h1000));
        check("ovf_irq", irq, IRQ_BUILD);
        tx_full = 1'b0;
        access(1'b1, A_STATUS, 16'h1000, 4'h0);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("ovf_cleared", s_rd, exp_status(2'b10, 16'h0));
        check("ovf_irq_drop", irq, 0);

        // ---- RX pop / underflow ----
        rx_empty = 1'b0; rx_data = 8'h3C;
        access(1'b0, A_DATA, 16'h0, 4'h0);
        check("pop_pulse", s_pop, 1);
        check("pop_rdata", s_rd, 16'h003C);
        check("pop_rvalid", s_rv, 1);
        rx_empty = 1'b1;
        access(1'b0, A_DATA, 16'h0, 4'h0);
        check("empty_no_pop", s_pop, 0);
        check("empty_rdata", s_rd, 16'h0000);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("unf_status", s_rd, exp_status(2'b10, 16'h2000));
        check("unf_masked_irq", irq, 0);
        access(1'b1, A_STATUS, 16'h3000, 4'h0);

        // ---- set wins over W1C ----
        access(1'b1, A_INT_EN, 16'h0002, 4'h0);
        access(1'b1, A_STATUS, 16'h0002, 4'b0001);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("setwins_fe", s_rd[1], 1);
        check("setwins_irq", irq, IRQ_BUILD);
        access(1'b1, A_STATUS, 16'h0002, 4'h0);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("w1c_fe", s_rd, exp_status(2'b10, 16'h0));
        check("w1c_irq_drop", irq, 0);

        // ---- drain ----
        tx_busy = 1'b1; tx_empty = 1'b0;
        access(1'b1, A_CONFIG, 16'h0063, 4'h0);
        @(posedge clk); #1;
        check("drain_baudgen", baudgen_en, 1);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("drain_state", s_rd[15:14], 2'b11);
        tx_full = 1'b1;
        access(1'b1, A_DATA, 16'h0055, 4'h0);
        check("drain_no_push", s_push, 0);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("drain_no_ovf", s_rd[12], 0);
        tx_full = 1'b0;
        @(negedge clk);
        tx_busy = 1'b0; tx_empty = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(posedge clk); #1;
            if (!baudgen_en) done = 1'b1;
        end
        check("drain_done", done, 1);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("drain_disabled", s_rd, exp_status(2'b00, 16'h0));

        // ---- reset while running ----
        access(1'b1, A_CONFIG, 16'h8063, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rerun_baudgen", baudgen_en, 1);
        access(1'b0, A_ZERO, 16'h0, 4'b1000);
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("pre_rst_status", s_rd, exp_status(2'b10, 16'h0010));
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rdata", bus_rdata, 0);
        check("mid_rst_rvalid", bus_rvalid, 0);
        check("mid_rst_baudgen", baudgen_en, 0);
        check("mid_rst_cfg_bits", cfg_bits, 8);
        check("mid_rst_cfg_en", {cfg_tx_en, cfg_rx_en}, 0);
        check("mid_rst_baud_div", baud_div, 0);
        check("mid_rst_irq", irq, 0);
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, A_STATUS, 16'h0, 4'h0);
        check("post_rst_status", s_rd, exp_status(2'b00, 16'h0));

        // ---- randomized phase against the model ----
        do_reset();
        b = 16'($urandom);
        access(1'b1, A_INT_EN, 16'h301E, 4'h0);
        access(1'b1, A_BAUD, b, 4'h0);
        access(1'b1, A_CONFIG, 16'h8063, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rnd_baud_div", baud_div, b);
        m_sticky = 16'h0;
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 5);
            wd = 16'($urandom);
            err = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tx_full = 1'($urandom); rx_empty = 1'($urandom);
            tx_busy = 1'($urandom); rx_full = 1'($urandom); tx_empty = 1'($urandom);
            tx_lvl_irq = 1'($urandom); rx_lvl_irq = 1'($urandom);
            rx_data = 8'($urandom);
            tx_count = 5'($urandom); rx_count = 5'($urandom);
            m_set = {11'b0, err, 1'b0};
            m_clr = 16'h0;
            case (op)
                0: begin
                    access(1'b1, A_DATA, wd, err);
                    check("rnd_push", s_push, !tx_full);
                    if (!tx_full) check("rnd_txd", s_txd, wd[7:0]);
                    if (tx_full) m_set[12] = 1'b1;
                end
                1: begin
                    access(1'b0, A_DATA, 16'h0, err);
                    check("rnd_pop", s_pop, !rx_empty);
                    check("rnd_rxd", s_rd, rx_empty ? 16'h0 : {8'h00, rx_data});
                    if (rx_empty) m_set[13] = 1'b1;
                end
                2: begin
                    access(1'b1, A_STATUS, wd, err);
                    m_clr = wd;
                end
                3: begin
                    access(1'b1, A_CONFIG, wd | 16'h8000, err);
                    access(1'b1, A_BAUD, ~b, 4'h0);
                    cfg_seen = {cfg_bits, cfg_tx_en, cfg_rx_en, cfg_par_en, cfg_stop2, 8'h00};
                    check("rnd_shadow_hold", cfg_seen, 16'h8C00);
                    check("rnd_baud_hold", baud_div, b);
                end
                4: begin
                    access(1'b0, A_LEVEL, 16'h0, err);
                    check("rnd_level", s_rd, 16'(rx_count) * 32 + 16'(tx_count));
                end
                default: begin
                    access(1'b0, A_ZERO, 16'h0, err);
                    check("rnd_zero", s_rd, 0);
                end
            endcase
            m_sticky = (m_sticky & ~(m_clr & 16'h301E)) | m_set;
            access(1'b0, A_STATUS, 16'h0, 4'h0);
            check("rnd_status", s_rd, exp_status(2'b10, m_sticky));
            check("rnd_irq", irq, IRQ_BUILD && (m_sticky != 16'h0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
